pulse2level: RTL and testbench

- Inverse of the level-to-pulse edge detector: rebuilds a level from single-cycle rise, fall and double (toggle) event pulses.
- Enforces a minimum hold time between level changes and queues one request that arrives during the hold.
- Emits a stretched indication pulse on every effective level change.
- Sits at the receiving end of event-pulse paths, where a block needs a stable level again.

---
 rtl/pulse2level.sv | 221 ++++++++++++++++++++++
 tb/tb_pulse2level.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse2level.sv
`default_nettype none
// ============================================================================
// Module      : pulse2level
// Description : Rebuilds a stable level from single-cycle rise / fall /
//               double (toggle) event pulses. A minimum hold time separates
//               level changes. One request arriving during the hold is kept in
//               a pending slot; newer requests overwrite it and are counted as
//               drops. Every effective level change also raises a stretched
//               indication pulse.
//
// Ports       : clk         - clock, all logic on the rising edge
//               rst_n       - synchronous active-low reset
//               rise_in     - set-level request pulse
//               fall_in     - clear-level request pulse
//               double_in   - toggle-level request pulse
//               level_out   - registered reconstructed level
//               stretch_out - high STRETCH_LEN cycles after each change
//               busy        - hold counter running or a request pending
//               drop_cnt    - saturating count of overwritten requests
//
// Revision    : 1.0 - initial release
// ============================================================================
module pulse2level #(
    parameter logic INIT_LEVEL  = 1'b0,
    parameter int   MIN_HOLD    = 2,
    parameter int   STRETCH_LEN = 4,
    parameter int   RETRIGGER   = 1,
    parameter int   CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rise_in,
    input  logic             fall_in,
    input  logic             double_in,
    output logic             level_out,
    output logic             stretch_out,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt
);

    // Counter widths, never narrower than one bit.
    localparam int c_HOLD_W = (MIN_HOLD < 1) ? 1 : $clog2(MIN_HOLD + 1);
    localparam int c_STR_W  = (STRETCH_LEN < 2) ? 1 : $clog2(STRETCH_LEN);

    localparam logic [c_HOLD_W-1:0] c_MIN_HOLD     = c_HOLD_W'(MIN_HOLD);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE     = c_HOLD_W'(1);
    localparam logic [c_STR_W-1:0]  c_STRETCH_LOAD = c_STR_W'(STRETCH_LEN - 1);
    localparam logic [c_STR_W-1:0]  c_STR_ONE      = c_STR_W'(1);
    localparam logic [CNT_W-1:0]    c_DROP_ONE     = CNT_W'(1);

    // FSM encoding
    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_HOLD      = 2'd1;
    localparam logic [1:0] c_ST_HOLD_PEND = 2'd2;

    // Request kinds. A toggle is stored as a kind, not as a target level, so
    // a queued toggle inverts whatever the level is when it is finally applied.
    localparam logic [1:0] c_K_SET    = 2'd0;
    localparam logic [1:0] c_K_CLEAR  = 2'd1;
    localparam logic [1:0] c_K_TOGGLE = 2'd2;

    logic [1:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold;
    logic                r_pend_v;
    logic [1:0]          r_pend_kind;
    logic [CNT_W-1:0]    r_drop;
    logic                r_level;
    logic                r_busy;
    logic                r_stretch;
    logic [c_STR_W-1:0]  r_str_cnt;

    logic                w_req_valid;
    logic [1:0]          w_req_kind;
    logic                w_hold_zero;
    logic [1:0]          w_next_state;
    logic [c_HOLD_W-1:0] w_next_hold;
    logic                w_next_pend_v;
    logic [1:0]          w_next_pend_kind;
    logic [CNT_W-1:0]    w_next_drop;
    logic                w_next_level;
    logic                w_apply;
    logic [1:0]          w_apply_kind;
    logic                w_drop_inc;
    logic                w_target;
    logic                w_change;

    // Request decode: double_in, or rise and fall together, means toggle.
    assign w_req_valid = double_in | rise_in | fall_in;
    assign w_req_kind  = (double_in || (rise_in && fall_in)) ? c_K_TOGGLE :
                         rise_in                             ? c_K_SET    :
                                                               c_K_CLEAR;
    assign w_hold_zero = (r_hold == '0);

    always_comb begin
        w_next_state     = r_state;
        w_next_hold      = r_hold;
        w_next_pend_v    = r_pend_v;
        w_next_pend_kind = r_pend_kind;
        w_next_drop      = r_drop;
        w_next_level     = r_level;
        w_apply          = 1'b0;
        w_apply_kind     = w_req_kind;
        w_drop_inc       = 1'b0;
        w_target         = r_level;
        w_change         = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_apply = w_req_valid;
            end
            c_ST_HOLD: begin
                if (!w_hold_zero) begin
                    w_next_hold = r_hold - c_HOLD_ONE;
                    if (w_req_valid) begin
                        w_next_pend_v    = 1'b1;
                        w_next_pend_kind = w_req_kind;
                        w_next_state     = c_ST_HOLD_PEND;
                    end
                end else if (w_req_valid) begin
                    w_apply = 1'b1;
                end else begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_HOLD_PEND: begin
                if (!w_hold_zero) begin
                    w_next_hold = r_hold - c_HOLD_ONE;
                    if (w_req_valid) begin
                        w_next_pend_kind = w_req_kind;
                        w_drop_inc       = 1'b1;
                    end
                end else begin
                    // Hold expired: a fresh request wins over the queued one.
                    w_apply       = 1'b1;
                    w_next_pend_v = 1'b0;
                    if (w_req_valid) begin
                        w_drop_inc = 1'b1;
                    end else begin
                        w_apply_kind = r_pend_kind;
                    end
                end
            end
            default: begin
                w_next_state  = c_ST_IDLE;
                w_next_hold   = '0;
                w_next_pend_v = 1'b0;
            end
        endcase

        if (w_apply) begin
            case (w_apply_kind)
                c_K_SET:   w_target = 1'b1;
                c_K_CLEAR: w_target = 1'b0;
                default:   w_target = ~r_level;
            endcase
            w_change = (w_target != r_level);
            if (w_change) begin
                w_next_level = w_target;
                if (MIN_HOLD > 0) begin
                    w_next_hold  = c_MIN_HOLD;
                    w_next_state = c_ST_HOLD;
                end else begin
                    w_next_hold  = '0;
                    w_next_state = c_ST_IDLE;
                end
            end else begin
                // No-op request: nothing to hold off, so settle in IDLE.
                w_next_hold  = '0;
                w_next_state = c_ST_IDLE;
            end
        end

        if (w_drop_inc && (r_drop != '1)) begin
            w_next_drop = r_drop + c_DROP_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_hold      <= '0;
            r_pend_v    <= 1'b0;
            r_pend_kind <= c_K_SET;
            r_drop      <= '0;
            r_level     <= INIT_LEVEL;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_hold      <= w_next_hold;
            r_pend_v    <= w_next_pend_v;
            r_pend_kind <= w_next_pend_kind;
            r_drop      <= w_next_drop;
            r_level     <= w_next_level;
            r_busy      <= (w_next_hold != '0) | w_next_pend_v;
        end
    end

    // Stretcher: the counter holds the number of further high cycles left.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stretch <= 1'b0;
            r_str_cnt <= '0;
        end else if (w_change && (!r_stretch || (RETRIGGER != 0))) begin
            r_stretch <= 1'b1;
            r_str_cnt <= c_STRETCH_LOAD;
        end else if (r_stretch) begin
            if (r_str_cnt == '0) begin
                r_stretch <= 1'b0;
            end else begin
                r_str_cnt <= r_str_cnt - c_STR_ONE;
            end
        end
    end

    assign level_out   = r_level;
    assign stretch_out = r_stretch;
    assign busy        = r_busy;
    assign drop_cnt    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pulse2level.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse2level
// Description : Self-checking bench for pulse2level. Three instances cover
//               the default configuration, a longer hold, and a
//               non-retriggering stretcher with no hold.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse2level;

    typedef struct {
        int         cyc;
        logic       lvl;
        logic       str;
        logic       bsy;
        logic [7:0] drp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic a_rise, a_fall, a_double;
    logic b_rise, b_fall, b_double;
    logic c_rise, c_fall, c_double;
    logic a_level, a_stretch, a_busy;
    logic b_level, b_stretch, b_busy;
    logic c_level, c_stretch, c_busy;
    logic [7:0] a_drop, b_drop, c_drop;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    pulse2level u_dut_a (
        .clk(clk), .rst_n(rst_n), .rise_in(a_rise), .fall_in(a_fall),
        .double_in(a_double), .level_out(a_level), .stretch_out(a_stretch),
        .busy(a_busy), .drop_cnt(a_drop)
    );

    pulse2level #(.MIN_HOLD(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rise_in(b_rise), .fall_in(b_fall),
        .double_in(b_double), .level_out(b_level), .stretch_out(b_stretch),
        .busy(b_busy), .drop_cnt(b_drop)
    );

    pulse2level #(.MIN_HOLD(0), .STRETCH_LEN(6), .RETRIGGER(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .rise_in(c_rise), .fall_in(c_fall),
        .double_in(c_double), .level_out(c_level), .stretch_out(c_stretch),
        .busy(c_busy), .drop_cnt(c_drop)
    );

    function automatic void push(int c, logic l, logic s, logic b, logic [7:0] d);
        exp_t x;
        x.cyc = c; x.lvl = l; x.str = s; x.bsy = b; x.drp = d;
        sb.push_back(x);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_rise = 0; a_fall = 0; a_double = 0;
        b_rise = 0; b_fall = 0; b_double = 0;
        c_rise = 0; c_fall = 0; c_double = 0;
    endtask

    // After this returns, the next edge begins cycle 0.
    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset_and_rise();
        do_reset();
        push(0, 0, 0, 0, 0); push(3, 0, 0, 0, 0); push(5, 0, 0, 0, 0);
        push(6, 1, 1, 1, 0); push(7, 1, 1, 1, 0); push(8, 1, 1, 0, 0);
        push(9, 1, 1, 0, 0); push(10, 1, 0, 0, 0); push(11, 1, 0, 0, 0);
        for (int k = 0; k <= 11; k++) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == k) begin
                e = sb.pop_front();
                checks++;
                if ({a_level, a_stretch, a_busy, a_drop} !== {e.lvl, e.str, e.bsy, e.drp}) begin
                    errors++;
                    $display("FAIL rise cyc=%0d got lvl=%b str=%b busy=%b drop=%0d exp lvl=%b str=%b busy=%b drop=%0d",
                             k, a_level, a_stretch, a_busy, a_drop, e.lvl, e.str, e.bsy, e.drp);
                end
            end
            a_fall = (k == 2);
            a_rise = (k == 5);
        end
        clear_inputs();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rise_leftover got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_pending_apply();
        do_reset();
        push(6, 1, 1, 1, 0); push(7, 1, 1, 1, 0); push(8, 1, 1, 1, 0);
        push(9, 0, 1, 1, 0); push(10, 0, 1, 1, 0); push(11, 0, 1, 0, 0);
        push(12, 0, 1, 0, 0); push(13, 0, 0, 0, 0);
        for (int k = 0; k <= 13; k++) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == k) begin
                e = sb.pop_front();
                checks++;
                if ({a_level, a_stretch, a_busy, a_drop} !== {e.lvl, e.str, e.bsy, e.drp}) begin
                    errors++;
                    $display("FAIL pending cyc=%0d got lvl=%b str=%b busy=%b drop=%0d exp lvl=%b str=%b busy=%b drop=%0d",
                             k, a_level, a_stretch, a_busy, a_drop, e.lvl, e.str, e.bsy, e.drp);
                end
            end
            a_rise = (k == 5);
            a_fall = (k == 6);
        end
        clear_inputs();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_leftover got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_toggle();
        do_reset();
        push(6, 1, 1, 1, 0); push(7, 1, 1, 1, 0); push(8, 1, 1, 0, 0);
        push(9, 1, 1, 0, 0); push(10, 1, 0, 0, 0); push(11, 0, 1, 1, 0);
        push(12, 0, 1, 1, 0); push(13, 0, 1, 0, 0);
        for (int k = 0; k <= 13; k++) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == k) begin
                e = sb.pop_front();
                checks++;
                if ({a_level, a_stretch, a_busy, a_drop} !== {e.lvl, e.str, e.bsy, e.drp}) begin
                    errors++;
                    $display("FAIL toggle cyc=%0d got lvl=%b str=%b busy=%b drop=%0d exp lvl=%b str=%b busy=%b drop=%0d",
                             k, a_level, a_stretch, a_busy, a_drop, e.lvl, e.str, e.bsy, e.drp);
                end
            end
            a_rise   = (k == 5);
            a_fall   = (k == 5) || (k == 10);
            a_double = (k == 10);
        end
        clear_inputs();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL toggle_leftover got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_overwrite_drop();
        do_reset();
        push(6, 1, 1, 1, 0); push(7, 1, 1, 1, 0); push(8, 1, 1, 1, 1);
        push(9, 1, 1, 1, 2); push(10, 1, 0, 1, 2); push(11, 1, 0, 0, 2);
        push(12, 1, 0, 0, 2);
        for (int k = 0; k <= 12; k++) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == k) begin
                e = sb.pop_front();
                checks++;
                if ({b_level, b_stretch, b_busy, b_drop} !== {e.lvl, e.str, e.bsy, e.drp}) begin
                    errors++;
                    $display("FAIL overwrite cyc=%0d got lvl=%b str=%b busy=%b drop=%0d exp lvl=%b str=%b busy=%b drop=%0d",
                             k, b_level, b_stretch, b_busy, b_drop, e.lvl, e.str, e.bsy, e.drp);
                end
            end
            b_rise   = (k == 5) || (k == 8);
            b_fall   = (k == 6);
            b_double = (k == 7);
        end
        clear_inputs();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL overwrite_leftover got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_no_retrigger();
        do_reset();
        push(6, 1, 1, 0, 0); push(7, 1, 1, 0, 0); push(8, 0, 1, 0, 0);
        push(9, 0, 1, 0, 0); push(11, 0, 1, 0, 0); push(12, 0, 0, 0, 0);
        push(13, 0, 0, 0, 0);
        for (int k = 0; k <= 13; k++) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == k) begin
                e = sb.pop_front();
                checks++;
                if ({c_level, c_stretch, c_busy, c_drop} !== {e.lvl, e.str, e.bsy, e.drp}) begin
                    errors++;
                    $display("FAIL no_retrig cyc=%0d got lvl=%b str=%b busy=%b drop=%0d exp lvl=%b str=%b busy=%b drop=%0d",
                             k, c_level, c_stretch, c_busy, c_drop, e.lvl, e.str, e.bsy, e.drp);
                end
            end
            c_rise = (k == 5);
            c_fall = (k == 7);
        end
        clear_inputs();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL no_retrig_leftover got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(7, 1, 1, 1, 0); push(8, 1, 1, 1, 0); push(9, 0, 1, 1, 1);
        push(10, 0, 1, 1, 1); push(11, 0, 1, 0, 1); push(12, 0, 1, 0, 1);
        push(13, 0, 0, 0, 1);
        for (int k = 0; k <= 13; k++) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == k) begin
                e = sb.pop_front();
                checks++;
                if ({a_level, a_stretch, a_busy, a_drop} !== {e.lvl, e.str, e.bsy, e.drp}) begin
                    errors++;
                    $display("FAIL back_to_back cyc=%0d got lvl=%b str=%b busy=%b drop=%0d exp lvl=%b str=%b busy=%b drop=%0d",
                             k, a_level, a_stretch, a_busy, a_drop, e.lvl, e.str, e.bsy, e.drp);
                end
            end
            a_rise   = (k == 5);
            a_fall   = (k == 6);
            a_double = (k == 8);
        end
        clear_inputs();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL back_to_back_leftover got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        push(7, 1, 1, 1, 0); push(8, 0, 0, 0, 0); push(9, 0, 0, 0, 0);
        push(10, 0, 0, 0, 0); push(11, 0, 0, 0, 0); push(12, 0, 0, 0, 0);
        for (int k = 0; k <= 12; k++) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == k) begin
                e = sb.pop_front();
                checks++;
                if ({a_level, a_stretch, a_busy, a_drop} !== {e.lvl, e.str, e.bsy, e.drp}) begin
                    errors++;
                    $display("FAIL mid_reset cyc=%0d got lvl=%b str=%b busy=%b drop=%0d exp lvl=%b str=%b busy=%b drop=%0d",
                             k, a_level, a_stretch, a_busy, a_drop, e.lvl, e.str, e.bsy, e.drp);
                end
            end
            a_rise = (k == 5);
            a_fall = (k == 6);
            rst_n  = (k != 7);
        end
        clear_inputs();
        rst_n = 1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_leftover got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset_and_rise();
        test_pending_apply();
        test_toggle();
        test_overwrite_drop();
        test_no_retrigger();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
